// File: rtl/dds_serial_ctrl_if.sv
// Command/response and pin bundle between the DDS register block and the serial engine.
// No latency: plain wires grouped for port convenience.
// No backpressure: Busy is the only flow-control signal (Start is ignored while Busy).
// Ports (slave = serial engine view):
//   Start, DataOut[31:0], WR, Send  - command from the register block
//   Busy, DataIn[31:0]              - status and read-back to the register block
//   DDS_SCLK, DDS_CS_n, DDS_SDO, DDS_SDO_OE, DDS_IO_UPDATE - pins driven to the DDS
//   DDS_SDI                         - serial data returned by the DDS
interface dds_serial_ctrl_if;
  logic        Start;
  logic [31:0] DataOut;
  logic        WR;
  logic        Send;
  logic        Busy;
  logic [31:0] DataIn;
  logic        DDS_SCLK;
  logic        DDS_CS_n;
  logic        DDS_SDO;
  logic        DDS_SDO_OE;
  logic        DDS_SDI;
  logic        DDS_IO_UPDATE;

  // Register block plus DDS pad side.
  modport master (
    output Start, DataOut, WR, Send, DDS_SDI,
    input  Busy, DataIn, DDS_SCLK, DDS_CS_n, DDS_SDO, DDS_SDO_OE, DDS_IO_UPDATE
  );

  // Serial engine side.
  modport slave (
    input  Start, DataOut, WR, Send, DDS_SDI,
    output Busy, DataIn, DDS_SCLK, DDS_CS_n, DDS_SDO, DDS_SDO_OE, DDS_IO_UPDATE
  );
endinterface

// File: rtl/dds_serial_ctrl.sv
// Serial engine: turns one Start into a 32-bit 3-wire frame (8-bit instruction + 24-bit data) to the DDS.
// Latency: Busy/CS_n assert the cycle after Start; Busy high (2*32+2)*CLK_DIV cycles, +UPD_WIDTH when Send.
// Backpressure: Start is only accepted in IDLE; Start and command changes while Busy are ignored.
// Ports:
//   APB_0_axiclk  - sole clock
//   APB_0_areset  - synchronous active-high reset, aborts any frame at the next edge
//   bus (slave)   - Start/DataOut/WR/Send in, Busy/DataIn out, DDS pin outputs, DDS_SDI in
module dds_serial_ctrl #(
  parameter int CLK_DIV    = 4,  // SCLK half-period in clocks, >= 1
  parameter int INSTR_BITS = 8,  // bits always driven by the master before read turnaround
  parameter int UPD_WIDTH  = 4   // IO_UPDATE pulse width in clocks, >= 1
) (
  input  logic             APB_0_axiclk,
  input  logic             APB_0_areset,
  dds_serial_ctrl_if.slave bus
);

  localparam int            CW       = 16;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] UPD_LAST = CW'(UPD_WIDTH - 1);
  localparam logic [4:0]    TURN_BIT = 5'(INSTR_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, UPDATE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // cycles spent in the current phase
  logic [4:0]    bit_q, bit_d;     // index of the bit currently on the wire (MSB = 0)
  logic [30:0]   tx_q, tx_d;       // bits still to be sent after the one on DDS_SDO
  logic [23:0]   cap_q, cap_d;     // last 24 SDI samples
  logic          wr_q, wr_d;
  logic          send_q, send_d;
  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          csn_q, csn_d;
  logic          sdo_q, sdo_d;
  logic          oe_q, oe_d;
  logic          upd_q, upd_d;
  logic [31:0]   din_q, din_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    cap_d   = cap_q;
    wr_d    = wr_q;
    send_d  = send_q;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    csn_d   = csn_q;
    sdo_d   = sdo_q;
    oe_d    = oe_q;
    upd_d   = upd_q;
    din_d   = din_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.Start) begin
          state_d = SETUP;
          bit_d   = '0;
          tx_d    = bus.DataOut[30:0];
          wr_d    = bus.WR;
          send_d  = bus.Send;
          busy_d  = 1'b1;
          csn_d   = 1'b0;
          sdo_d   = bus.DataOut[31];
          oe_d    = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT_HI;
          cnt_d   = '0;
          sclk_d  = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT_LO;
          cnt_d   = '0;
          sclk_d  = 1'b0;
          // Sample just before the falling edge, giving the DDS the whole high phase to drive SDI.
          cap_d   = {cap_q[22:0], bus.DDS_SDI};
          sdo_d   = tx_q[30];
          tx_d    = {tx_q[29:0], 1'b0};
          // Read frames hand the SDIO pad to the DDS once the instruction has been clocked out.
          if (!wr_q && bit_q == TURN_BIT) begin
            oe_d = 1'b0;
          end
        end
      end
      SHIFT_LO: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == 5'd31) begin
            state_d = HOLD;
          end else begin
            state_d = SHIFT_HI;
            sclk_d  = 1'b1;
            bit_d   = bit_q + 5'd1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          csn_d = 1'b1;
          oe_d  = 1'b0;
          sdo_d = 1'b0;
          if (!wr_q) begin
            din_d = {8'h00, cap_q};
          end
          if (send_q) begin
            state_d = UPDATE;
            upd_d   = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      UPDATE: begin
        if (cnt_q == UPD_LAST) begin
          state_d = IDLE;
          upd_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge APB_0_axiclk) begin
    if (APB_0_areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      cap_q   <= '0;
      wr_q    <= 1'b0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      sdo_q   <= 1'b0;
      oe_q    <= 1'b0;
      upd_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      cap_q   <= cap_d;
      wr_q    <= wr_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      csn_q   <= csn_d;
      sdo_q   <= sdo_d;
      oe_q    <= oe_d;
      upd_q   <= upd_d;
      din_q   <= din_d;
    end
  end

  assign bus.Busy          = busy_q;
  assign bus.DataIn        = din_q;
  assign bus.DDS_SCLK      = sclk_q;
  assign bus.DDS_CS_n      = csn_q;
  assign bus.DDS_SDO       = sdo_q;
  assign bus.DDS_SDO_OE    = oe_q;
  assign bus.DDS_IO_UPDATE = upd_q;

endmodule

// File: tb/tb_dds_serial_ctrl.sv
// Bench for dds_serial_ctrl: one instance with CLK_DIV=4 and one with CLK_DIV=1.
// A timeline model (outputs as a function of cycles since Start) is compared every cycle,
// plus literal expectations for the reference frames.
module tb_dds_serial_ctrl;
  localparam int UPD = 4;
  localparam int IB  = 8;

  logic clk;
  logic rst;

  dds_serial_ctrl_if c4 ();
  dds_serial_ctrl_if c1 ();

  dds_serial_ctrl #(.CLK_DIV(4), .INSTR_BITS(IB), .UPD_WIDTH(UPD)) dut4 (
    .APB_0_axiclk(clk), .APB_0_areset(rst), .bus(c4));
  dds_serial_ctrl #(.CLK_DIV(1), .INSTR_BITS(IB), .UPD_WIDTH(UPD)) dut1 (
    .APB_0_axiclk(clk), .APB_0_areset(rst), .bus(c1));

  logic        start_v [2];
  logic [31:0] dout_v  [2];
  logic        wr_v    [2];
  logic        send_v  [2];
  logic [31:0] rd_word_v [2];
  logic        sdi0;

  assign c4.Start = start_v[0];  assign c1.Start = start_v[1];
  assign c4.DataOut = dout_v[0]; assign c1.DataOut = dout_v[1];
  assign c4.WR = wr_v[0];        assign c1.WR = wr_v[1];
  assign c4.Send = send_v[0];    assign c1.Send = send_v[1];
  assign c4.DDS_SDI = sdi0;      assign c1.DDS_SDI = 1'b0;

  logic        busy_v [2], sclk_v [2], csn_v [2], sdo_v [2], oe_v [2], upd_v [2];
  logic [31:0] din_v  [2];
  assign busy_v[0] = c4.Busy;        assign busy_v[1] = c1.Busy;
  assign sclk_v[0] = c4.DDS_SCLK;    assign sclk_v[1] = c1.DDS_SCLK;
  assign csn_v[0]  = c4.DDS_CS_n;    assign csn_v[1]  = c1.DDS_CS_n;
  assign sdo_v[0]  = c4.DDS_SDO;     assign sdo_v[1]  = c1.DDS_SDO;
  assign oe_v[0]   = c4.DDS_SDO_OE;  assign oe_v[1]   = c1.DDS_SDO_OE;
  assign upd_v[0]  = c4.DDS_IO_UPDATE; assign upd_v[1] = c1.DDS_IO_UPDATE;
  assign din_v[0]  = c4.DataIn;      assign din_v[1]  = c1.DataIn;

  int   n_chk;
  int   n_err;
  logic model_on;

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", name, d, $time, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DDS slave: presents the next read-word bit on SDI after each SCLK rising edge.
  initial begin
    int   nr;
    logic prev;
    nr = 0; prev = 1'b0; sdi0 = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (c4.DDS_CS_n !== 1'b0) begin
        nr = 0;
      end else if (c4.DDS_SCLK === 1'b1 && !prev && nr < 32) begin
        sdi0 = rd_word_v[0][31-nr];
        nr++;
      end
      prev = (c4.DDS_SCLK === 1'b1);
    end
  end

  // Timeline model: c = cycles since the accepting edge (0 = first SETUP cycle).
  int          m_c   [2];
  int          m_len [2];
  logic        m_act [2], m_wr [2], m_send [2];
  logic [31:0] m_data [2], m_rd [2], m_din [2];

  initial begin
    int D, c, j;
    logic e_busy, e_csn, e_sclk, e_oe, e_upd, e_sdo;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_c[d] = 0; m_len[d] = 0; m_din[d] = '0;
      m_wr[d] = 1'b0; m_send[d] = 1'b0; m_data[d] = '0; m_rd[d] = '0;
    end
    forever begin
      @(negedge clk);
      if (model_on) begin
        for (int d = 0; d < 2; d++) begin
          D = div_of(d);
          c = m_c[d];
          if (!m_act[d]) begin
            e_busy = 1'b0; e_csn = 1'b1; e_sclk = 1'b0; e_oe = 1'b0; e_upd = 1'b0;
          end else begin
            e_busy = 1'b1;
            e_csn  = (c >= 66*D);
            e_sclk = (c >= D) && (c < 65*D) && ((((c - D) / D) % 2) == 0);
            e_oe   = (c < 66*D) && (m_wr[d] || c < 2*D*IB);
            e_upd  = m_send[d] && (c >= 66*D);
          end
          chk("busy", d, busy_v[d], e_busy);
          chk("cs_n", d, csn_v[d], e_csn);
          chk("sclk", d, sclk_v[d], e_sclk);
          chk("sdo_oe", d, oe_v[d], e_oe);
          chk("io_update", d, upd_v[d], e_upd);
          chk("datain", d, din_v[d], m_din[d]);
          if (m_act[d] && e_oe) begin
            j = (c < D) ? 0 : (((c - D) / D) + 1) / 2;
            if (j < 32) begin
              e_sdo = m_data[d][31-j];
              chk("sdo", d, sdo_v[d], e_sdo);
            end
          end
          // Advance to the state after the coming edge.
          if (rst) begin
            m_act[d] = 1'b0;
            m_din[d] = '0;
          end else if (m_act[d]) begin
            m_c[d]++;
            if (m_c[d] == 66*D && !m_wr[d]) m_din[d] = {8'h00, m_rd[d][23:0]};
            if (m_c[d] == m_len[d]) m_act[d] = 1'b0;
          end else if (start_v[d]) begin
            m_act[d]  = 1'b1;
            m_c[d]    = 0;
            m_data[d] = dout_v[d];
            m_wr[d]   = wr_v[d];
            m_send[d] = send_v[d];
            m_rd[d]   = rd_word_v[d];
            m_len[d]  = 66*D + (send_v[d] ? UPD : 0);
          end
        end
      end
    end
  end

  // Runs one frame on instance d. poke: extra Start pulses at cycles 10/100 and a held Start
  // from cycle 200 with command changes; rst_cyc: cycle during which reset is driven high.
  task automatic frame(input int d, input logic [31:0] data, input logic wr, input logic send,
                       input logic poke, input int rst_cyc,
                       output int busy_n, output int rises, output logic [31:0] sdo_w,
                       output int upd_n, output int oe_n);
    logic prev;
    int   n;
    busy_n = 0; rises = 0; sdo_w = '0; upd_n = 0; oe_n = 0; prev = 1'b0; n = 0;
    @(posedge clk); #1;
    start_v[d] = 1'b1; dout_v[d] = data; wr_v[d] = wr; send_v[d] = send;
    do begin
      @(posedge clk); #1;
      n++;
      start_v[d] = poke && (n == 10 || n == 100 || n >= 200);
      if (poke && (n == 10 || n == 100 || n == 200)) begin
        dout_v[d] = $urandom; wr_v[d] = ~wr_v[d]; send_v[d] = ~send_v[d];
      end
      rst = (n == rst_cyc);
      @(negedge clk);
      if (busy_v[d]) busy_n++;
      if (upd_v[d]) upd_n++;
      if (busy_v[d] && oe_v[d]) oe_n++;
      if (sclk_v[d] && !prev) begin
        rises++;
        sdo_w = {sdo_w[30:0], sdo_v[d]};
      end
      prev = sclk_v[d];
    end while (busy_v[d] && n < 1000);
    chk("busy_fell", d, busy_v[d], 1'b0);
  endtask

  initial begin
    int          bn, rs, un, on, D, n;
    logic [31:0] sw;
    logic        w, s;
    rst = 1'b1; model_on = 1'b0; n_chk = 0; n_err = 0;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; dout_v[d] = '0; wr_v[d] = 1'b0; send_v[d] = 1'b0; rd_word_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 model_on = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, busy_v[d], 1'b0);
      chk("rst_datain", d, din_v[d], 32'h0);
      chk("rst_sclk", d, sclk_v[d], 1'b0);
      chk("rst_cs_n", d, csn_v[d], 1'b1);
      chk("rst_sdo", d, sdo_v[d], 1'b0);
      chk("rst_oe", d, oe_v[d], 1'b0);
      chk("rst_upd", d, upd_v[d], 1'b0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Write frame, no IO_UPDATE.
    frame(0, 32'hA5C30F81, 1'b1, 1'b0, 1'b0, -1, bn, rs, sw, un, on);
    chk("wr_busy_cycles", 0, bn, 264);
    chk("wr_rises", 0, rs, 32);
    chk("wr_sdo_bits", 0, sw, 32'hA5C30F81);
    chk("wr_upd_cycles", 0, un, 0);
    chk("wr_oe_cycles", 0, on, 264);
    chk("wr_datain", 0, din_v[0], 32'h0);

    // Same frame with IO_UPDATE.
    frame(0, 32'hA5C30F81, 1'b1, 1'b1, 1'b0, -1, bn, rs, sw, un, on);
    chk("send_busy_cycles", 0, bn, 268);
    chk("send_upd_cycles", 0, un, UPD);
    chk("send_rises", 0, rs, 32);

    // Reset during bit 17 of a read frame.
    rd_word_v[0] = 32'hC3_654321;
    frame(0, 32'h80000000, 1'b0, 1'b0, 1'b0, 142, bn, rs, sw, un, on);
    chk("abort_busy_cycles", 0, bn, 142);
    chk("abort_cs_n", 0, csn_v[0], 1'b1);
    chk("abort_sclk", 0, sclk_v[0], 1'b0);
    chk("abort_datain", 0, din_v[0], 32'h0);
    repeat (3) @(posedge clk);

    // Clean read frame after the abort.
    rd_word_v[0] = 32'h5A_123456;
    frame(0, 32'h80000000, 1'b0, 1'b0, 1'b0, -1, bn, rs, sw, un, on);
    chk("rd_busy_cycles", 0, bn, 264);
    chk("rd_oe_cycles", 0, on, 64);
    chk("rd_datain", 0, din_v[0], 32'h00123456);

    // Start pulses and command changes mid-frame, then Start held into the first IDLE cycle.
    rd_word_v[0] = $urandom;
    frame(0, 32'h3C5A96E1, 1'b1, 1'b0, 1'b1, -1, bn, rs, sw, un, on);
    chk("poke_busy_cycles", 0, bn, 264);
    chk("poke_sdo_bits", 0, sw, 32'h3C5A96E1);
    chk("poke_upd_cycles", 0, un, 0);
    @(posedge clk); #1 start_v[0] = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 0, busy_v[0], 1'b1);
    n = 0;
    while (busy_v[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_busy_fell", 0, busy_v[0], 1'b0);

    // CLK_DIV=1 write of all ones.
    frame(1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, -1, bn, rs, sw, un, on);
    chk("div1_busy_cycles", 1, bn, 66);
    chk("div1_rises", 1, rs, 32);
    chk("div1_sdo_bits", 1, sw, 32'hFFFFFFFF);

    // Random frames on both instances.
    for (int i = 0; i < 8; i++) begin
      int d;
      d = i % 2;
      D = div_of(d);
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (d == 0) rd_word_v[0] = $urandom;
      frame(d, $urandom, w, s, 1'b0, -1, bn, rs, sw, un, on);
      chk("rand_busy_cycles", d, bn, 66*D + (s ? UPD : 0));
      chk("rand_rises", d, rs, 32);
      chk("rand_upd_cycles", d, un, s ? UPD : 0);
    end

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
